mem_bus_arbiter: RTL and testbench

//  Sequences the shared SRAM-like memory port between the fetch stage (instruction reads) and the mem stage (loads/stores).

---
 rtl/mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and mem stage; one transaction in flight, >= 3 cycles each.
// Requesters are stalled via inst_busy/data_busy; bus_* fields hold steady until bus_addr_ok.
module mem_bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_ok,
   output logic [31:0]       inst_rdata,
   output logic              inst_busy,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_ok,
   output logic [31:0]       data_rdata,
   output logic              data_err,
   output logic              data_busy,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_wstrb,
   output logic [31:0]       bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [31:0]       bus_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t              state_q, state_d;
   logic                owner_data_q, owner_data_d;
   logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_wr_q, bus_wr_d;
   logic [1:0]          bus_size_q, bus_size_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [3:0]          bus_wstrb_q, bus_wstrb_d;
   logic [31:0]         bus_wdata_q, bus_wdata_d;
   logic                inst_ok_q, inst_ok_d;
   logic                data_ok_q, data_ok_d;
   logic                data_err_q, data_err_d;
   logic [31:0]         inst_rdata_q, inst_rdata_d;
   logic [31:0]         data_rdata_q, data_rdata_d;

   logic                starved;
   logic                grant_data;
   logic                grant_inst;
   logic                misaligned;
   logic [3:0]          fmt_wstrb;
   logic [31:0]         fmt_wdata;

   // Priority: data first, except once inst has watched STARVE_MAX data grants go by.
   always_comb begin
      starved    = (starve_cnt_q == CNT_W'(STARVE_MAX)) && inst_req;
      grant_data = data_req && !starved;
      grant_inst = inst_req && !grant_data;
   end

   always_comb begin
      misaligned = 1'b0;
      case (data_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = data_addr[0];
         default: misaligned = (data_addr[1:0] != 2'b00);
      endcase
   end

   // Right-aligned store data is replicated across every lane it could land in.
   always_comb begin
      fmt_wstrb = 4'b0000;
      fmt_wdata = 32'h0;
      if (data_wr) begin
         case (data_size)
            2'b00: begin
               fmt_wstrb = 4'b0001 << data_addr[1:0];
               fmt_wdata = {4{data_wdata[7:0]}};
            end
            2'b01: begin
               fmt_wstrb = 4'b0011 << data_addr[1:0];
               fmt_wdata = {2{data_wdata[15:0]}};
            end
            default: begin
               fmt_wstrb = 4'b1111;
               fmt_wdata = data_wdata;
            end
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_data_d = owner_data_q;
      starve_cnt_d = starve_cnt_q;
      bus_req_d    = bus_req_q;
      bus_wr_d     = bus_wr_q;
      bus_size_d   = bus_size_q;
      bus_addr_d   = bus_addr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_wdata_d  = bus_wdata_q;
      inst_ok_d    = 1'b0;
      data_ok_d    = 1'b0;
      data_err_d   = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_data) begin
               owner_data_d = 1'b1;
               if (inst_req && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end
               if (misaligned) begin
                  data_err_d = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  bus_req_d   = 1'b1;
                  bus_wr_d    = data_wr;
                  bus_size_d  = data_size;
                  bus_addr_d  = data_addr;
                  bus_wstrb_d = fmt_wstrb;
                  bus_wdata_d = fmt_wdata;
                  state_d     = S_ADDR;
               end
            end else if (grant_inst) begin
               owner_data_d = 1'b0;
               starve_cnt_d = '0;
               bus_req_d    = 1'b1;
               bus_wr_d     = 1'b0;
               bus_size_d   = 2'b10;
               bus_addr_d   = inst_addr;
               bus_wstrb_d  = 4'b0000;
               bus_wdata_d  = 32'h0;
               state_d      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bus_data_ok) begin
               if (owner_data_q) begin
                  data_rdata_d = bus_rdata;
                  data_ok_d    = 1'b1;
               end else begin
                  inst_rdata_d = bus_rdata;
                  inst_ok_d    = 1'b1;
               end
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         owner_data_q <= 1'b0;
         starve_cnt_q <= '0;
         bus_req_q    <= 1'b0;
         bus_wr_q     <= 1'b0;
         bus_size_q   <= 2'b00;
         bus_addr_q   <= '0;
         bus_wstrb_q  <= 4'b0000;
         bus_wdata_q  <= 32'h0;
         inst_ok_q    <= 1'b0;
         data_ok_q    <= 1'b0;
         data_err_q   <= 1'b0;
         inst_rdata_q <= 32'h0;
         data_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         owner_data_q <= owner_data_d;
         starve_cnt_q <= starve_cnt_d;
         bus_req_q    <= bus_req_d;
         bus_wr_q     <= bus_wr_d;
         bus_size_q   <= bus_size_d;
         bus_addr_q   <= bus_addr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_wdata_q  <= bus_wdata_d;
         inst_ok_q    <= inst_ok_d;
         data_ok_q    <= data_ok_d;
         data_err_q   <= data_err_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign inst_ok    = inst_ok_q;
   assign inst_rdata = inst_rdata_q;
   assign inst_busy  = inst_req & ~inst_ok_q;
   assign data_ok    = data_ok_q;
   assign data_rdata = data_rdata_q;
   assign data_err   = data_err_q;
   assign data_busy  = data_req & ~(data_ok_q | data_err_q);
   assign bus_req    = bus_req_q;
   assign bus_wr     = bus_wr_q;
   assign bus_size   = bus_size_q;
   assign bus_addr   = bus_addr_q;
   assign bus_wstrb  = bus_wstrb_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the arbiter.
// The bench plays the memory bus with chosen address/data delays.
module tb_mem_bus_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ok;
   logic [31:0] inst_rdata;
   logic        inst_busy;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ok;
   logic [31:0] data_rdata;
   logic        data_err;
   logic        data_busy;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   int   checks = 0;
   int   errors = 0;
   int   sc     = 0;
   logic last_win_data;

   mem_bus_arbiter #(.ADDR_W(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_ok(inst_ok),
      .inst_rdata(inst_rdata), .inst_busy(inst_busy),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_ok(data_ok),
      .data_rdata(data_rdata), .data_err(data_err), .data_busy(data_busy),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected {wstrb, wdata} for a data request, straight from the lane rules.
   function automatic logic [35:0] exp_store(input logic wr, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
      int unsigned off;
      logic [3:0]  s;
      logic [31:0] d;
      off = a % 4;
      if (!wr) return 36'h0;
      case (sz)
         2'd0: begin s = 4'(1 << off); d = (wd & 32'hFF) * 32'h0101_0101; end
         2'd1: begin s = 4'(3 << off); d = (wd & 32'hFFFF) * 32'h0001_0001; end
         default: begin s = 4'hF; d = wd; end
      endcase
      return {s, d};
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1'b0;
      if (sz == 2'd1) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   // Called at the negedge of an IDLE cycle with requests already driven.
   // Returns at the negedge of the response cycle with the winner's request dropped.
   task automatic round(input int adly, input int ddly);
      logic        win_d;
      logic        mis;
      logic [35:0] st;
      logic [70:0] exp_f;
      logic [31:0] rd;
      win_d = data_req && !(sc == SM && inst_req);
      if (win_d) begin
         if (inst_req && sc < SM) sc++;
      end else begin
         sc = 0;
      end
      mis   = win_d && is_misaligned(data_size, data_addr);
      st    = exp_store(data_wr, data_size, data_addr, data_wdata);
      exp_f = win_d ? {data_wr, data_size, data_addr, st} : {1'b0, 2'b10, inst_addr, 36'h0};
      rd    = $urandom;
      last_win_data = win_d;
      @(posedge clk); @(negedge clk);
      if (mis) begin
         chk("err_pulse", data_err, 1'b1);
         chk("err_no_ok", data_ok, 1'b0);
         chk("err_no_bus", bus_req, 1'b0);
         chk("err_busy", data_busy, 1'b0);
         chk("err_ibusy", inst_busy, inst_req);
         data_req = 1'b0;
         return;
      end
      chk("grant_req", bus_req, 1'b1);
      chk("grant_fields", {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, exp_f);
      chk("wait_ibusy", inst_busy, inst_req);
      chk("wait_dbusy", data_busy, data_req);
      for (int i = 0; i < adly; i++) begin
         bus_data_ok = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         bus_data_ok = 1'b0;
         chk("addr_hold_req", bus_req, 1'b1);
         chk("addr_hold_fields", {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, exp_f);
         chk("addr_no_ok", {inst_ok, data_ok}, 2'b00);
      end
      bus_addr_ok = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_addr_ok = 1'b0;
      chk("addr_drop", bus_req, 1'b0);
      for (int i = 0; i < ddly; i++) begin
         @(posedge clk); @(negedge clk);
         chk("data_wait_no_ok", {inst_ok, data_ok, bus_req}, 3'b000);
      end
      bus_data_ok = 1'b1;
      bus_rdata   = rd;
      @(posedge clk); @(negedge clk);
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (win_d) begin
         chk("d_ok", {data_ok, inst_ok, data_err}, 3'b100);
         chk("d_rdata", data_rdata, rd);
         chk("d_busy", data_busy, 1'b0);
         data_req = 1'b0;
      end else begin
         chk("i_ok", {inst_ok, data_ok, data_err}, 3'b100);
         chk("i_rdata", inst_rdata, rd);
         chk("i_busy", inst_busy, 1'b0);
         inst_req = 1'b0;
      end
   endtask

   task automatic next_idle();
      @(negedge clk);
      chk("pulse_end", {inst_ok, data_ok, data_err, bus_req}, 4'b0000);
   endtask

   task automatic set_data(input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
      data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
   endtask

   initial begin
      logic [9:0] pat;
      rst = 1'b1;
      inst_req = 1'b0; inst_addr = 32'h0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'b00; data_addr = 32'h0; data_wdata = 32'h0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
      last_win_data = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus", {bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, 71'h0);
      chk("rst_pulses", {inst_ok, data_ok, data_err}, 3'b000);
      chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
      rst = 1'b0;
      @(negedge clk);

      // Word load, zero-wait bus
      set_data(1'b0, 2'b10, 32'h100, 32'h0);
      round(0, 0); next_idle();
      // Byte and half stores
      set_data(1'b1, 2'b00, 32'h203, 32'h0000_00AB);
      round(0, 0);
      chk("sb_lanes", {bus_wstrb, bus_wdata}, {4'b1000, 32'hABAB_ABAB});
      next_idle();
      set_data(1'b1, 2'b01, 32'h202, 32'h0000_1234);
      round(1, 2);
      chk("sh_lanes", {bus_wstrb, bus_wdata}, {4'b1100, 32'h1234_1234});
      next_idle();
      // Misaligned word load
      set_data(1'b0, 2'b10, 32'h101, 32'h0);
      round(0, 0); next_idle();
      chk("mis_no_ok", {data_ok, bus_req}, 2'b00);
      // Fetch with address phase stretched by 5 cycles
      inst_req = 1'b1; inst_addr = 32'h400;
      round(5, 1); next_idle();

      // Both held continuously: starvation guard order
      pat = 10'b01111_01111;
      inst_req = 1'b1; inst_addr = 32'h800;
      for (int r = 0; r < 10; r++) begin
         if (!inst_req) begin inst_req = 1'b1; inst_addr = 32'h800 + 32'(r * 4); end
         if (!data_req) set_data(1'b0, 2'b10, 32'h1000 + 32'(r * 4), 32'h0);
         round(0, 0);
         chk("starve_order", last_win_data, pat[r]);
         next_idle();
      end
      inst_req = 1'b0; data_req = 1'b0;
      @(negedge clk);

      // Reset while waiting in the data phase
      set_data(1'b0, 2'b10, 32'h300, 32'h0);
      @(posedge clk); @(negedge clk);
      bus_addr_ok = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_addr_ok = 1'b0;
      rst = 1'b1; data_req = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; sc = 0;
      bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      chk("rst_mid_req", bus_req, 1'b0);
      @(posedge clk); @(negedge clk);
      bus_data_ok = 1'b0;
      chk("rst_mid_no_ok", {inst_ok, data_ok, data_err}, 3'b000);
      chk("rst_mid_rdata", data_rdata, 32'h0);
      inst_req = 1'b1; inst_addr = 32'h40;
      round(0, 0); next_idle();

      // Randomized traffic
      for (int r = 0; r < 60; r++) begin
         if (!inst_req && $urandom_range(0, 1) == 1) begin
            inst_req = 1'b1; inst_addr = {$urandom} & 32'hFFFF_FFFC;
         end
         if (!data_req && $urandom_range(0, 2) != 0)
            set_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
         if (!inst_req && !data_req) begin
            inst_req = 1'b1; inst_addr = {$urandom} & 32'hFFFF_FFFC;
         end
         round($urandom_range(0, 3), $urandom_range(0, 3));
         next_idle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
